// File: rtl/rs_issue_sched_pkg.sv
// rtl/rs_issue_sched_pkg.sv - shared constants and types for the RS issue scheduler
package rs_issue_sched_pkg;
    localparam int NUM_RS = 4;
    localparam int IDX_W  = $clog2(NUM_RS);
    typedef logic [IDX_W-1:0] rs_idx_t;
endpackage

// File: rtl/age_matrix_sel.sv
// rtl/age_matrix_sel.sv - age matrix over RS slots; picks the oldest eligible slot
module age_matrix_sel #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic [N-1:0] occ,
    input  logic [N-1:0] elig,
    input  logic [N-1:0] we,
    input  logic [N-1:0] re,
    output logic [N-1:0] oldest
);
    // older[i][j]: slot i was written before slot j
    logic [N-1:0] older [N];
    logic [N-1:0] occ_post;

    assign occ_post = occ & ~re;

    always_comb begin
        oldest = elig;
        for (int i = 0; i < N; i++) begin
            for (int j = 0; j < N; j++) begin
                if (j != i && elig[j] && older[j][i]) begin
                    oldest[i] = 1'b0;
                end
            end
        end
    end

    // A newly written slot is younger than every slot still occupied after this cycle's grant
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < N; i++) begin
                older[i] <= '0;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (we[k]) begin
                    older[k] <= '0;
                    for (int j = 0; j < N; j++) begin
                        if (j != k) begin
                            older[j][k] <= occ_post[j];
                        end
                    end
                end
            end
        end
    end
endmodule

// File: rtl/rs_issue_sched.sv
// rtl/rs_issue_sched.sv - dispatch steering and oldest-ready issue for shared-ALU RS slots
module rs_issue_sched
    import rs_issue_sched_pkg::*;
#(
    parameter int NUM_RS = rs_issue_sched_pkg::NUM_RS,
    parameter int IDX_W  = $clog2(NUM_RS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              cache_stall,
    input  logic              disp_valid,
    output logic              disp_rdy,
    input  logic [NUM_RS-1:0] slot_write_rdy,
    input  logic [NUM_RS-1:0] slot_read_rdy,
    output logic [NUM_RS-1:0] slot_we,
    input  logic              alu_rdy,
    output logic [NUM_RS-1:0] slot_re,
    output logic              issue_valid,
    output logic [IDX_W-1:0]  issue_idx,
    output logic [31:0]       issue_cnt
);
    logic [NUM_RS-1:0] occ;
    logic [NUM_RS-1:0] elig;
    logic [NUM_RS-1:0] oldest;
    logic [NUM_RS-1:0] free;
    logic              grant_en;

    assign elig     = occ & slot_read_rdy;
    assign grant_en = alu_rdy & ~flush & ~rst;
    assign slot_re  = grant_en ? oldest : '0;

    age_matrix_sel #(.N(NUM_RS)) u_age (
        .clk    (clk),
        .rst    (rst),
        .flush  (flush),
        .occ    (occ),
        .elig   (elig),
        .we     (slot_we),
        .re     (slot_re),
        .oldest (oldest)
    );

    // Slot being drained this cycle is masked so grant and write never collide
    assign free        = slot_write_rdy & ~slot_re;
    assign disp_rdy    = (|free) & ~cache_stall & ~flush & ~rst;
    assign slot_we     = (disp_valid && disp_rdy) ? (free & (~free + NUM_RS'(1))) : '0;
    assign issue_valid = |slot_re;

    always_comb begin
        issue_idx = '0;
        for (int i = 0; i < NUM_RS; i++) begin
            if (slot_re[i]) begin
                issue_idx = IDX_W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            occ       <= '0;
            issue_cnt <= '0;
        end else begin
            occ <= (occ & ~slot_re) | slot_we;
            if (issue_valid) begin
                issue_cnt <= issue_cnt + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_rs_issue_sched.sv
// tb/tb_rs_issue_sched.sv - directed bench with timestamp-age reference model
module tb_rs_issue_sched;
    import rs_issue_sched_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        cache_stall = 1'b0;
    logic        disp_valid = 1'b0;
    logic        disp_rdy;
    logic [3:0]  slot_write_rdy = 4'b0;
    logic [3:0]  slot_read_rdy = 4'b0;
    logic [3:0]  slot_we;
    logic        alu_rdy = 1'b0;
    logic [3:0]  slot_re;
    logic        issue_valid;
    rs_idx_t     issue_idx;
    logic [31:0] issue_cnt;

    int total = 0;
    int bad = 0;
    bit chk_en = 1'b0;

    // Reference model: occupancy plus a dispatch sequence number per slot
    logic [3:0]  m_occ = 4'b0;
    int          m_ts [4];
    int          m_seq = 0;
    logic [31:0] m_cnt = 32'd0;

    rs_issue_sched dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .cache_stall    (cache_stall),
        .disp_valid     (disp_valid),
        .disp_rdy       (disp_rdy),
        .slot_write_rdy (slot_write_rdy),
        .slot_read_rdy  (slot_read_rdy),
        .slot_we        (slot_we),
        .alu_rdy        (alu_rdy),
        .slot_re        (slot_re),
        .issue_valid    (issue_valid),
        .issue_idx      (issue_idx),
        .issue_cnt      (issue_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            logic [3:0] e_re, e_we, e_free;
            logic       e_drdy, found;
            int         best;
            best = -1;
            for (int i = 0; i < 4; i++)
                if (m_occ[i] && slot_read_rdy[i] && (best < 0 || m_ts[i] < m_ts[best])) best = i;
            e_re = 4'b0;
            if (alu_rdy && !flush && !rst && best >= 0) e_re[best] = 1'b1;
            e_free = slot_write_rdy & ~e_re;
            e_drdy = (e_free != 4'b0) && !cache_stall && !flush && !rst;
            e_we = 4'b0;
            found = 1'b0;
            for (int i = 0; i < 4; i++)
                if (disp_valid && e_drdy && e_free[i] && !found) begin
                    e_we[i] = 1'b1;
                    found = 1'b1;
                end
            chk("m_slot_re", 32'(slot_re), 32'(e_re));
            chk("m_slot_we", 32'(slot_we), 32'(e_we));
            chk("m_disp_rdy", 32'(disp_rdy), 32'(e_drdy));
            chk("m_issue_valid", 32'(issue_valid), 32'(e_re != 4'b0));
            chk("m_issue_idx", 32'(issue_idx), (e_re != 4'b0) ? 32'(best) : 32'd0);
            chk("m_issue_cnt", issue_cnt, m_cnt);
            if (rst || flush) begin
                m_occ = 4'b0;
                m_cnt = 32'd0;
            end else begin
                m_occ = m_occ & ~e_re;
                if (e_re != 4'b0) m_cnt = m_cnt + 32'd1;
                for (int i = 0; i < 4; i++)
                    if (e_we[i]) begin
                        m_occ[i] = 1'b1;
                        m_ts[i] = m_seq;
                        m_seq++;
                    end
            end
        end
    end

    task automatic step(input logic r, input logic fl, input logic cs, input logic dv,
                        input logic ar, input logic [3:0] wr, input logic [3:0] rd);
        @(posedge clk);
        #1;
        rst = r; flush = fl; cache_stall = cs; disp_valid = dv;
        alu_rdy = ar; slot_write_rdy = wr; slot_read_rdy = rd;
        @(negedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] oh;
        int exp_idx [3];
        exp_idx = '{2, 0, 3};
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        step(1, 0, 0, 1, 1, 4'b1111, 4'b1111);
        chk("rst_disp_rdy", 32'(disp_rdy), 32'd0);
        chk("rst_slot_we", 32'(slot_we), 32'd0);
        chk("rst_slot_re", 32'(slot_re), 32'd0);
        chk("rst_issue_cnt", issue_cnt, 32'd0);

        // Fill all four slots; busy slots drop their write-ready
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, 1, 0, ~m_occ, 4'b0);
            oh = 4'b0001 << k;
            chk("fill_slot_we", 32'(slot_we), 32'(oh));
        end
        step(0, 0, 0, 1, 0, ~m_occ, 4'b0);
        chk("full_disp_rdy", 32'(disp_rdy), 32'd0);

        step(0, 1, 0, 0, 0, 4'b0, 4'b0);
        step(0, 0, 0, 1, 0, 4'b0100, 4'b0);
        step(0, 0, 0, 1, 0, 4'b0001, 4'b0);
        step(0, 0, 0, 1, 0, 4'b1000, 4'b0);
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 0, 1, 4'b0, 4'b1111);
            chk("order_issue_idx", 32'(issue_idx), 32'(exp_idx[k]));
            chk("order_issue_valid", 32'(issue_valid), 32'd1);
        end
        step(0, 0, 0, 0, 1, 4'b0, 4'b1111);
        chk("order_issue_cnt", issue_cnt, 32'd3);
        chk("empty_issue_valid", 32'(issue_valid), 32'd0);

        // Out-of-order: older slot 0 waits on operands
        step(0, 0, 0, 1, 0, 4'b0001, 4'b0);
        step(0, 0, 0, 1, 0, 4'b0010, 4'b0);
        step(0, 0, 0, 0, 1, 4'b0, 4'b0010);
        chk("ooo_young_re", 32'(slot_re), 32'h2);
        step(0, 0, 0, 0, 1, 4'b0, 4'b0011);
        chk("ooo_old_re", 32'(slot_re), 32'h1);

        // Slot 1 is granted and is the only write-ready slot
        step(0, 0, 0, 1, 0, 4'b0010, 4'b0);
        step(0, 0, 0, 1, 1, 4'b0010, 4'b0010);
        chk("collide_slot_re", 32'(slot_re), 32'h2);
        chk("collide_slot_we", 32'(slot_we), 32'h0);
        step(0, 0, 0, 1, 0, 4'b0010, 4'b0);
        chk("refill_slot_we", 32'(slot_we), 32'h2);
        step(0, 0, 0, 0, 1, 4'b0, 4'b0010);
        chk("drain_issue_cnt", issue_cnt, 32'd6);

        // ALU back-pressure, then cache stall with issue running
        step(0, 0, 0, 1, 0, 4'b0001, 4'b0);
        step(0, 0, 0, 1, 0, 4'b0010, 4'b0);
        step(0, 0, 0, 0, 0, 4'b0, 4'b0011);
        chk("alu_busy_slot_re", 32'(slot_re), 32'h0);
        chk("alu_busy_cnt", issue_cnt, 32'd7);
        step(0, 0, 1, 1, 1, 4'b1100, 4'b0011);
        chk("stall_disp_rdy", 32'(disp_rdy), 32'd0);
        chk("stall_slot_re", 32'(slot_re), 32'h1);

        // Flush with slots 1,2,3 occupied
        step(0, 0, 0, 1, 0, 4'b0100, 4'b0);
        step(0, 0, 0, 1, 0, 4'b1000, 4'b0);
        step(0, 1, 0, 1, 1, 4'b0001, 4'b1111);
        chk("flush_slot_re", 32'(slot_re), 32'h0);
        chk("flush_slot_we", 32'(slot_we), 32'h0);
        chk("flush_issue_valid", 32'(issue_valid), 32'd0);
        step(0, 0, 0, 0, 1, 4'b0, 4'b1111);
        chk("post_flush_valid", 32'(issue_valid), 32'd0);
        chk("post_flush_cnt", issue_cnt, 32'd0);

        step(0, 0, 0, 0, 0, 4'b0, 4'b0);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
